matrix_scan: RTL and testbench
==============================

MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 SHALL have parameter TIMERWIDTH, default 10, meaning row display dwell = 2**TIMERWIDTH clk cycles.
REQ-002 SHALL have parameter DIM, default 16, meaning matrix rows = columns = 16 (fixed; other values not supported).
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports x and y, inputs, 4 each, ball column and row.
REQ-006 SHALL have ports lpaddle and rpaddle, inputs, 16 each, paddle row masks with bit r = row r.
REQ-007 SHALL have ports rclk, rsdi, oeb, csdi, cclk and le, outputs, 1 each: row shift clock, row serial data, output-enable-bar, column serial data, column shift clock, column latch enable.
REQ-008 SHALL have port frame_done, output, 1, one-cycle pulse after row 15 dwell ends.

Function
REQ-009 SHALL snapshot x, y, lpaddle and rpaddle on entry to SHIFT for row 0 only, and hold the snapshot for the whole frame (no tearing).
REQ-010 SHALL compose row r column word as: bit0 = lpaddle[r], bit15 = rpaddle[r], bit x OR-set when y==r; overlaps OR together.
REQ-011 SHALL use states SHIFT -> LATCH -> DISPLAY -> SHIFT (next row); row counter 4 bits, wraps 15 -> 0.
REQ-012 SHALL in SHIFT emit 16 bits MSB (col 15) first, 2 cycles per bit: cycle A csdi = bit, cclk = 0; cycle B cclk = 1; 32 cycles total.
REQ-013 SHALL in LATCH take 2 cycles: cycle 1 le = 1, oeb = 1, rclk = 1, rsdi = (row==0); cycle 2 le = 0, rclk = 0, rsdi = 0.
REQ-014 SHALL in DISPLAY hold oeb = 0 for 2**TIMERWIDTH cycles, cclk = le = rclk = 0.
REQ-015 SHALL hold oeb = 1 throughout SHIFT and LATCH.
REQ-016 SHALL give row period exactly 34 + 2**TIMERWIDTH cycles and frame period 16x that.
REQ-017 SHALL pulse frame_done on the first cycle after row 15 DISPLAY ends, coincident with SHIFT row 0 first cycle.
REQ-018 SHALL leave input changes mid-frame invisible until next row-0 snapshot.

Reset
REQ-019 SHALL on reset assert immediately: oeb = 1; rclk, rsdi, csdi, cclk, le, frame_done = 0; row = 0; bit counter = 0; state = SHIFT.
REQ-020 SHALL on reset deassertion start row 0 SHIFT with a fresh snapshot on the first clk edge.
REQ-021 SHALL on reset mid-operation abandon the current row with no partial latch.

Configuration
REQ-022 SHALL with MATRIX_SCAN_DIM_EN defined add input brightness[1:0] and hold oeb = 0 only for the first (brightness+1)*2**(TIMERWIDTH-2) DISPLAY cycles, oeb = 1 for the remainder; row period unchanged.
REQ-023 SHALL without MATRIX_SCAN_DIM_EN have no brightness port and full-dwell oeb = 0.

Structure
REQ-024 SHALL place the DIM constant, the scan state enum and LATCH_CYCLES = 2 in shared package pong_pkg.
REQ-025 SHALL use one sub-module, col_serializer: loads the 16-bit word and emits csdi/cclk per REQ-012 with a done strobe; row sequencing stays in matrix_scan.

Verification
REQ-026 SHALL cover: x=5, y=3, paddles 0, TIMERWIDTH=4 -> only row 3 latches 0x0020; other rows latch 0x0000.
REQ-027 SHALL cover: lpaddle=0x0007, rpaddle=0x8000, y=15, x=15 -> rows 0-2 latch 0x0001; row 15 latches 0x8000 (overlap ORed).
REQ-028 SHALL cover: TIMERWIDTH=4 -> rsdi high only during row-0 LATCH, frame_done period 16*50 = 800 cycles, oeb low exactly 16 cycles per row.
REQ-029 SHALL cover: change x from 2 to 9 during row 7 SHIFT -> current frame shows 2; next frame shows 9.
REQ-030 SHALL cover: assert reset during row 9 DISPLAY -> oeb = 1 same cycle; after release row 0 SHIFT, rsdi pulse in first LATCH.
REQ-031 SHALL cover: with MATRIX_SCAN_DIM_EN, brightness=1, TIMERWIDTH=4 -> oeb low 8 of 16 DISPLAY cycles per row.

Source files
------------

// File: rtl/pong_pkg.sv
// pong_pkg: constants and types shared by the LED matrix scan logic.
//   DIM           - matrix rows/columns (fixed at 16)
//   LATCH_CYCLES  - cycles spent in the latch phase of each row
//   SHIFT_CYCLES  - cycles spent clocking one column word out (2 per bit)
//   scan_state_e  - row sequencing states
//   compose_row() - builds one row's column word from ball and paddles
package pong_pkg;

    localparam int DIM          = 16;
    localparam int LATCH_CYCLES = 2;
    localparam int SHIFT_CYCLES = 2 * DIM;

    typedef enum logic [1:0] {
        ST_SHIFT   = 2'd0,
        ST_LATCH   = 2'd1,
        ST_DISPLAY = 2'd2
    } scan_state_e;

    // Paddles live in the edge columns; the ball ORs on top of them.
    function automatic logic [DIM-1:0] compose_row(
        input logic [3:0]     bx,
        input logic [3:0]     by,
        input logic [DIM-1:0] lp,
        input logic [DIM-1:0] rp,
        input logic [3:0]     row
    );
        logic [DIM-1:0] w;
        w        = '0;
        w[0]     = lp[row];
        w[DIM-1] = rp[row];
        if (by == row) w[bx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/matrix_scan_col_serializer.sv
// col_serializer: shifts one 16-bit column word out MSB first.
//   clk, reset - system clock, async active-high reset
//   load       - capture word; the next cycle is cycle A of column 15
//   word       - column word to send
//   csdi, cclk - column serial data / shift clock (A: data, cclk=0; B: cclk=1)
//   busy       - a word is being shifted
//   done       - last cycle of the shift (cycle B of column 0)
module col_serializer
    import pong_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [DIM-1:0] word,
    output logic           csdi,
    output logic           cclk,
    output logic           busy,
    output logic           done
);

    localparam logic [4:0] CNT_LAST = 5'(SHIFT_CYCLES - 1);

    logic [DIM-1:0] shreg;
    logic [4:0]     cnt;

    assign done = busy && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            csdi  <= 1'b0;
            cclk  <= 1'b0;
        end else if (load) begin
            shreg <= {word[DIM-2:0], 1'b0};
            csdi  <= word[DIM-1];
            cclk  <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            cnt <= cnt + 5'd1;
            if (done) begin
                busy <= 1'b0;
                csdi <= 1'b0;
                cclk <= 1'b0;
            end else if (!cnt[0]) begin
                // cycle A -> B: data already stable, raise the clock
                cclk <= 1'b1;
            end else begin
                // cycle B -> next A: drop clock, present next bit
                cclk  <= 1'b0;
                csdi  <= shreg[DIM-1];
                shreg <= {shreg[DIM-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: row-multiplexed driver for a 16x16 pong LED matrix.
// Each row: SHIFT (32 cycles, column word out) -> LATCH (2 cycles, row
// token + column latch) -> DISPLAY (2**TIMERWIDTH cycles, outputs on).
// Ball/paddle inputs are snapshotted once per frame when row 0 loads.
// Optional feature: define MATRIX_SCAN_DIM_EN to add a brightness input
// that shortens the lit part of each DISPLAY dwell. TIMERWIDTH >= 3.
//   clk, reset          - system clock, async active-high reset
//   x, y                - ball column / row
//   lpaddle, rpaddle    - paddle row masks (bit r = row r)
//   brightness          - (MATRIX_SCAN_DIM_EN only) lit quarters minus one
//   rclk, rsdi          - row shift clock / row serial data (token)
//   oeb                 - output enable, active low
//   csdi, cclk, le      - column serial data / shift clock / latch enable
//   frame_done          - one-cycle pulse as row 0 of the next frame starts
module matrix_scan #(
    parameter int TIMERWIDTH = 10,
    parameter int DIM        = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     x,
    input  logic [3:0]     y,
    input  logic [DIM-1:0] lpaddle,
    input  logic [DIM-1:0] rpaddle,
`ifdef MATRIX_SCAN_DIM_EN
    input  logic [1:0]     brightness,
`endif
    output logic           rclk,
    output logic           rsdi,
    output logic           oeb,
    output logic           csdi,
    output logic           cclk,
    output logic           le,
    output logic           frame_done
);

    import pong_pkg::*;

    scan_state_e           state;
    logic [3:0]            row;
    logic                  lcnt;
    logic [TIMERWIDTH-1:0] timer;

    logic [3:0]     snap_x, snap_y;
    logic [DIM-1:0] snap_lp, snap_rp;

    logic           ser_busy, ser_done, ser_load;
    logic           disp_last, take_snap;
    logic [3:0]     row_load;
    logic [DIM-1:0] ser_word;

    assign disp_last = (state == ST_DISPLAY) && (timer == '1);

    // A row loads either straight out of reset (SHIFT with an idle
    // serializer) or on the last DISPLAY cycle, so rows abut exactly.
    assign ser_load  = ((state == ST_SHIFT) && !ser_busy) || disp_last;
    assign row_load  = disp_last ? row + 4'd1 : row;
    assign take_snap = ser_load && (row_load == 4'd0);

    // Row 0 must use the inputs being captured on this same edge.
    assign ser_word = take_snap ? compose_row(x, y, lpaddle, rpaddle, row_load)
                                : compose_row(snap_x, snap_y, snap_lp, snap_rp, row_load);

`ifdef MATRIX_SCAN_DIM_EN
    logic [2:0]            level;
    logic [TIMERWIDTH:0]   on_len;
    logic [TIMERWIDTH:0]   timer_inc;
    assign level     = {1'b0, brightness} + 3'd1;
    assign on_len    = {{(TIMERWIDTH-2){1'b0}}, level} << (TIMERWIDTH - 2);
    assign timer_inc = {1'b0, timer} + (TIMERWIDTH+1)'(1);
`endif

    col_serializer u_ser (
        .clk   (clk),
        .reset (reset),
        .load  (ser_load),
        .word  (ser_word),
        .csdi  (csdi),
        .cclk  (cclk),
        .busy  (ser_busy),
        .done  (ser_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_SHIFT;
            row        <= '0;
            lcnt       <= 1'b0;
            timer      <= '0;
            le         <= 1'b0;
            rclk       <= 1'b0;
            rsdi       <= 1'b0;
            oeb        <= 1'b1;
            frame_done <= 1'b0;
            snap_x     <= '0;
            snap_y     <= '0;
            snap_lp    <= '0;
            snap_rp    <= '0;
        end else begin
            frame_done <= 1'b0;
            if (take_snap) begin
                snap_x  <= x;
                snap_y  <= y;
                snap_lp <= lpaddle;
                snap_rp <= rpaddle;
            end
            case (state)
                ST_SHIFT: begin
                    if (ser_done) begin
                        state <= ST_LATCH;
                        lcnt  <= 1'b0;
                        le    <= 1'b1;
                        rclk  <= 1'b1;
                        rsdi  <= (row == 4'd0);
                    end
                end
                ST_LATCH: begin
                    if (lcnt == 1'(LATCH_CYCLES - 1)) begin
                        state <= ST_DISPLAY;
                        timer <= '0;
                        oeb   <= 1'b0;
                    end else begin
                        lcnt <= lcnt + 1'b1;
                        le   <= 1'b0;
                        rclk <= 1'b0;
                        rsdi <= 1'b0;
                    end
                end
                ST_DISPLAY: begin
                    if (timer == '1) begin
                        state      <= ST_SHIFT;
                        row        <= row + 4'd1;
                        oeb        <= 1'b1;
                        frame_done <= (row == 4'd15);
                    end else begin
                        timer <= timer + 1'b1;
`ifdef MATRIX_SCAN_DIM_EN
                        oeb   <= !(timer_inc < on_len);
`endif
                    end
                end
                default: state <= ST_SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// tb_matrix_scan: directed bench for matrix_scan with TIMERWIDTH=4
// (row period 50, frame period 800). Expected column words are queued per
// frame from a reference model and compared as each row latches.
module tb_matrix_scan;

    localparam int TW       = 4;
    localparam int ROW_PER  = 34 + (1 << TW);
    localparam int FRAME    = 16 * ROW_PER;
`ifdef MATRIX_SCAN_DIM_EN
    localparam int EXP_RUN  = 8;
`else
    localparam int EXP_RUN  = 1 << TW;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  x = '0, y = '0;
    logic [15:0] lpaddle = '0, rpaddle = '0;
`ifdef MATRIX_SCAN_DIM_EN
    logic [1:0]  brightness = 2'd1;
`endif
    logic rclk, rsdi, oeb, csdi, cclk, le, frame_done;

    int errors = 0;
    int checks = 0;

    typedef struct { int row; logic [15:0] word; } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    matrix_scan #(.TIMERWIDTH(TW), .DIM(16)) dut (
        .clk        (clk),
        .reset      (rst),
        .x          (x),
        .y          (y),
        .lpaddle    (lpaddle),
        .rpaddle    (rpaddle),
`ifdef MATRIX_SCAN_DIM_EN
        .brightness (brightness),
`endif
        .rclk       (rclk),
        .rsdi       (rsdi),
        .oeb        (oeb),
        .csdi       (csdi),
        .cclk       (cclk),
        .le         (le),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input int bx, input int by,
                                          input logic [15:0] lp, input logic [15:0] rp,
                                          input int r);
        logic [15:0] w;
        w = 16'h0000;
        if (lp[r]) w = w | 16'h0001;
        if (rp[r]) w = w | 16'h8000;
        if (by == r) w = w | (16'h0001 << bx);
        return w;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int r = 0; r < 16; r++) begin
            e.row  = r;
            e.word = model(int'(x), int'(y), lpaddle, rpaddle, r);
            sb.push_back(e);
        end
    endtask

    task automatic wait_frame_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2 * FRAME && !seen; i++) begin
            @(negedge clk);
            if (frame_done) seen = 1'b1;
        end
        if (!seen) check("frame_done_timeout", 0, 1);
    endtask

    // Monitor: rebuilds the shifted column word, checks latches, lit
    // dwell length and frame period.
    logic [15:0] sr;
    logic        cclk_q, le_q;
    int          mrow, run, cyc, last_fd;
    bit          fd_valid;
    initial begin
        sr = '0; cclk_q = 0; le_q = 0; mrow = 0; run = 0; cyc = 0; last_fd = 0; fd_valid = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sr = '0; run = 0; fd_valid = 0; cclk_q = 0; le_q = 0;
        end else begin
            if (cclk && !cclk_q) sr = {sr[14:0], csdi};
            if (le && !le_q) begin
                if (rsdi) mrow = 0; else mrow = mrow + 1;
                if (sb.size() == 0) begin
                    check("unexpected_latch", 0, 1);
                end else begin
                    e = sb.pop_front();
                    check("latch_row", mrow, e.row);
                    check("rsdi_token", rsdi, (e.row == 0));
                    check($sformatf("latch_word_r%0d", e.row), sr, e.word);
                end
            end
            if (rsdi) check("rsdi_only_with_le", le, 1);
            if (!oeb) run++;
            else if (run != 0) begin
                check("oeb_low_run", run, EXP_RUN);
                run = 0;
            end
            if (frame_done) begin
                if (fd_valid) check("frame_period", cyc - last_fd, FRAME);
                last_fd  = cyc;
                fd_valid = 1;
            end
            cclk_q = cclk;
            le_q   = le;
            cyc++;
        end
    end

    initial begin
        // Reset state
        x = 4'd5; y = 4'd3; lpaddle = '0; rpaddle = '0;
        #12;
        check("rst_oeb", oeb, 1);
        check("rst_rclk", rclk, 0);
        check("rst_rsdi", rsdi, 0);
        check("rst_csdi", csdi, 0);
        check("rst_cclk", cclk, 0);
        check("rst_le", le, 0);
        check("rst_frame_done", frame_done, 0);

        // Ball only: row 3 gets 0x0020
        push_frame();
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk);

        // Paddles plus ball in the corner, overlapping rpaddle
        lpaddle = 16'h0007; rpaddle = 16'h8000; x = 4'd15; y = 4'd15;
        wait_frame_done();
        push_frame();

        // Mid-frame change must not tear
        lpaddle = '0; rpaddle = '0; x = 4'd2; y = 4'd7;
        wait_frame_done();
        push_frame();
        repeat (7 * ROW_PER + 5) @(negedge clk);
        x = 4'd9;
        wait_frame_done();
        push_frame();

        // Reset during row 9 DISPLAY
        repeat (9 * ROW_PER + 34 + 6) @(negedge clk);
        check("pre_rst_oeb_lit", oeb, 0);
        #2 rst = 1'b1;
        #1;
        check("midrst_oeb", oeb, 1);
        check("midrst_le", le, 0);
        check("midrst_cclk", cclk, 0);
        sb.delete();
        x = 4'd12;
        push_frame();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        wait_frame_done();
        check("scoreboard_drained", sb.size(), 0);

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
